// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl
// Control stage in front of the LED blink counter. The run switch and the
// faster/slower push-buttons are synchronized and debounced. The block keeps
// a 3-bit rate level and drives the counter's enable and terminal count.
// When the rate changes while running, o_en is dropped for one cycle in the
// same cycle the new o_freq appears, so the counter restarts cleanly.
//
// Build option: define BLINK_RATE_WRAP_EN to make the level wrap (7->0 on up,
// 0->7 on down). Without it, the level saturates at 0 and 7.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   i_sw_run  raw run switch (async, active-high)
//   i_btn_up  raw "faster" button (async, active-high)
//   i_btn_dn  raw "slower" button (async, active-high)
//   o_en      registered enable to the blink counter
//   o_freq    registered toggle period in clk cycles, max(BASE_PERIOD >> level, 1)
//   o_level   registered rate level, 0 = slowest
//
// Handshake: none. Presses are single-cycle pulses derived internally from
// debounced rising edges; there is no valid/ready flow on this block.
module blink_rate_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BASE_PERIOD     = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_sw_run,
  input  logic        i_btn_up,
  input  logic        i_btn_dn,
  output logic        o_en,
  output logic [31:0] o_freq,
  output logic [2:0]  o_level
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0]      BASE_W  = 32'(BASE_PERIOD);

  // Channel order inside the packed vectors: bit 0 run, bit 1 up, bit 2 dn.
  localparam int CH_RUN = 0;
  localparam int CH_UP  = 1;
  localparam int CH_DN  = 2;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       db_q, db_d, db_prev_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic             up_press, dn_press, run;
  logic [2:0]       level_q, level_d;
  logic [31:0]      freq_q, freq_d, shifted;
  logic             level_change;

  state_t           state_q, state_d;
  logic             en_q, en_d;

  assign raw = {i_btn_dn, i_btn_up, i_sw_run};

  // Debounce: count consecutive cycles of disagreement; any agreement clears
  // the count. Reaching DEBOUNCE_CYCLES accepts the new level.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if ((cnt_q[i] + CNT_ONE) == CNT_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign run      = db_q[CH_RUN];
  assign up_press = db_q[CH_UP] & ~db_prev_q[CH_UP];
  assign dn_press = db_q[CH_DN] & ~db_prev_q[CH_DN];

  // Level and period next-state. Opposite presses in the same cycle cancel.
  always_comb begin
    level_d = level_q;
    if (up_press && !dn_press) begin
`ifdef BLINK_RATE_WRAP_EN
      level_d = level_q + 3'd1;
`else
      if (level_q != 3'd7) level_d = level_q + 3'd1;
`endif
    end else if (dn_press && !up_press) begin
`ifdef BLINK_RATE_WRAP_EN
      level_d = level_q - 3'd1;
`else
      if (level_q != 3'd0) level_d = level_q - 3'd1;
`endif
    end
    shifted = BASE_W >> level_d;
    freq_d  = (shifted == 32'd0) ? 32'd1 : shifted;
  end

  // Only a real change of level counts; a saturated press is a no-op.
  assign level_change = (level_d != level_q);

  // Run=0 wins over a level change; the level register still updates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run)              state_d = ST_STOP;
        else if (level_change) state_d = ST_RELOAD;
      end
      ST_RELOAD: begin
        if (!run)              state_d = ST_STOP;
        else if (level_change) state_d = ST_RELOAD;
        else                   state_d = ST_RUN;
      end
      default: state_d = ST_STOP;
    endcase
    en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      level_q   <= '0;
      freq_q    <= BASE_W;
      state_q   <= ST_STOP;
      en_q      <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      level_q   <= level_d;
      freq_q    <= freq_d;
      state_q   <= state_d;
      en_q      <= en_d;
    end
  end

  assign o_en    = en_q;
  assign o_freq  = freq_q;
  assign o_level = level_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl with DEBOUNCE_CYCLES=4, BASE_PERIOD=64.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A raw change before rising edge E1 is debounced at E6 and acted on at E7.
module tb_blink_rate_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_sw_run;
  logic        i_btn_up;
  logic        i_btn_dn;
  logic        o_en;
  logic [31:0] o_freq;
  logic [2:0]  o_level;

  int checks = 0;
  int errors = 0;

  blink_rate_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BASE_PERIOD    (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_sw_run(i_sw_run),
    .i_btn_up(i_btn_up),
    .i_btn_dn(i_btn_dn),
    .o_en    (o_en),
    .o_freq  (o_freq),
    .o_level (o_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: hold the given buttons, record observations, then release and
  // let the release debounce. drops counts sampled cycles with o_en=0.
  task automatic press_btn(input logic up, input logic dn,
                           output logic [2:0] lvl6, output logic [2:0] lvl,
                           output logic [31:0] frq, output logic en7,
                           output logic en8, output int drops);
    drops = 0;
    i_btn_up = up;
    i_btn_dn = dn;
    repeat (6) begin @(negedge clk); if (!o_en) drops++; end
    lvl6 = o_level;
    @(negedge clk); if (!o_en) drops++;
    lvl = o_level; frq = o_freq; en7 = o_en;
    @(negedge clk); if (!o_en) drops++;
    en8 = o_en;
    i_btn_up = 1'b0;
    i_btn_dn = 1'b0;
    repeat (8) begin @(negedge clk); if (!o_en) drops++; end
  endtask

  task automatic test_reset();
    int drops;
    reset_n = 1'b0; i_sw_run = 1'b1; i_btn_up = 1'b1; i_btn_dn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", o_en); end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", o_level); end
    checks++; if (o_freq !== 32'd64) begin errors++; $display("FAIL reset_freq: got %0d expected 64", o_freq); end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en_e6: got %0b expected 0", o_en); end
    @(negedge clk);
    checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL reset_en_e7: got %0b expected 1", o_en); end
    // up and dn were debounced together: cancel out
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level_e7: got %0d expected 0", o_level); end
    i_btn_up = 1'b0; i_btn_dn = 1'b0;
    drops = 0;
    repeat (10) begin @(negedge clk); if (!o_en) drops++; end
    checks++; if (drops !== 0) begin errors++; $display("FAIL reset_release_drops: got %0d expected 0", drops); end
  endtask

  task automatic test_bounce();
    int drops = 0;
    for (int i = 0; i < 5; i++) begin
      i_btn_up = 1'b1;
      repeat (2) begin @(negedge clk); if (!o_en) drops++; end
      i_btn_up = 1'b0;
      repeat (2) begin @(negedge clk); if (!o_en) drops++; end
    end
    repeat (10) begin @(negedge clk); if (!o_en) drops++; end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL bounce_level: got %0d expected 0", o_level); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL bounce_drops: got %0d expected 0", drops); end
  endtask

  task automatic test_rate_change();
    logic [2:0] lvl6, lvl; logic [31:0] frq; logic en7, en8; int drops;
    press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl6 !== 3'd0) begin errors++; $display("FAIL rate_level_early: got %0d expected 0", lvl6); end
    checks++; if (lvl !== 3'd1) begin errors++; $display("FAIL rate_level: got %0d expected 1", lvl); end
    checks++; if (frq !== 32'd32) begin errors++; $display("FAIL rate_freq: got %0d expected 32", frq); end
    checks++; if (en7 !== 1'b0) begin errors++; $display("FAIL rate_en_drop: got %0b expected 0", en7); end
    checks++; if (en8 !== 1'b1) begin errors++; $display("FAIL rate_en_back: got %0b expected 1", en8); end
    checks++; if (drops !== 1) begin errors++; $display("FAIL rate_drop_count: got %0d expected 1", drops); end
  endtask

`ifdef BLINK_RATE_WRAP_EN
  task automatic test_wrap();
    logic [2:0] lvl6, lvl; logic [31:0] frq; logic en7, en8; int drops;
    for (int i = 0; i < 6; i++) begin
      press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
      checks++; if (lvl !== 3'(i + 2)) begin errors++; $display("FAIL wrap_climb_level: got %0d expected %0d", lvl, i + 2); end
    end
    press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd0) begin errors++; $display("FAIL wrap_up_level: got %0d expected 0", lvl); end
    checks++; if (frq !== 32'd64) begin errors++; $display("FAIL wrap_up_freq: got %0d expected 64", frq); end
    checks++; if (drops !== 1 || en7 !== 1'b0) begin errors++; $display("FAIL wrap_up_drop: got %0d/%0b expected 1/0", drops, en7); end
    press_btn(1'b0, 1'b1, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd7) begin errors++; $display("FAIL wrap_dn_level: got %0d expected 7", lvl); end
    checks++; if (frq !== 32'd1) begin errors++; $display("FAIL wrap_dn_freq: got %0d expected 1", frq); end
    checks++; if (drops !== 1) begin errors++; $display("FAIL wrap_dn_drop: got %0d expected 1", drops); end
    press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd0) begin errors++; $display("FAIL wrap_back_level: got %0d expected 0", lvl); end
  endtask
`else
  task automatic test_saturation();
    logic [2:0] lvl6, lvl; logic [31:0] frq; logic en7, en8; int drops;
    for (int i = 0; i < 6; i++) begin
      press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
      checks++; if (lvl !== 3'(i + 2)) begin errors++; $display("FAIL sat_climb_level: got %0d expected %0d", lvl, i + 2); end
    end
    checks++; if (frq !== 32'd1) begin errors++; $display("FAIL sat_top_freq: got %0d expected 1", frq); end
    press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd7) begin errors++; $display("FAIL sat_top_level: got %0d expected 7", lvl); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL sat_top_drops: got %0d expected 0", drops); end
    for (int i = 0; i < 7; i++) press_btn(1'b0, 1'b1, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd0) begin errors++; $display("FAIL sat_down_level: got %0d expected 0", lvl); end
    checks++; if (frq !== 32'd64) begin errors++; $display("FAIL sat_down_freq: got %0d expected 64", frq); end
    press_btn(1'b0, 1'b1, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd0) begin errors++; $display("FAIL sat_bottom_level: got %0d expected 0", lvl); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL sat_bottom_drops: got %0d expected 0", drops); end
  endtask
`endif

  task automatic test_simultaneous();
    logic [2:0] lvl6, lvl; logic [31:0] frq; logic en7, en8; int drops;
    press_btn(1'b1, 1'b1, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd0) begin errors++; $display("FAIL simul_level: got %0d expected 0", lvl); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL simul_drops: got %0d expected 0", drops); end
  endtask

  task automatic test_run_fall_with_press();
    i_sw_run = 1'b0;
    i_btn_up = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL runfall_en_e6: got %0b expected 1", o_en); end
    @(negedge clk);
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL runfall_en_e7: got %0b expected 0", o_en); end
    checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL runfall_level: got %0d expected 1", o_level); end
    checks++; if (o_freq !== 32'd32) begin errors++; $display("FAIL runfall_freq: got %0d expected 32", o_freq); end
    repeat (2) @(negedge clk);
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL runfall_stays_stop: got %0b expected 0", o_en); end
    i_btn_up = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_stop_press();
    logic [2:0] lvl6, lvl; logic [31:0] frq; logic en7, en8; int drops;
    press_btn(1'b1, 1'b0, lvl6, lvl, frq, en7, en8, drops);
    checks++; if (lvl !== 3'd2) begin errors++; $display("FAIL stop_level: got %0d expected 2", lvl); end
    checks++; if (frq !== 32'd16) begin errors++; $display("FAIL stop_freq: got %0d expected 16", frq); end
    checks++; if (en7 !== 1'b0 || en8 !== 1'b0) begin errors++; $display("FAIL stop_en: got %0b%0b expected 00", en7, en8); end
  endtask

  task automatic test_mid_reset();
    i_sw_run = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_en: got %0b expected 1", o_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL midrst_en: got %0b expected 0", o_en); end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", o_level); end
    checks++; if (o_freq !== 32'd64) begin errors++; $display("FAIL midrst_freq: got %0d expected 64", o_freq); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL midrst_en_e6: got %0b expected 0", o_en); end
    @(negedge clk);
    checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL midrst_en_e7: got %0b expected 1", o_en); end
  endtask

  initial begin
    reset_n = 1'b0; i_sw_run = 1'b0; i_btn_up = 1'b0; i_btn_dn = 1'b0;
    test_reset();
    test_bounce();
    test_rate_change();
`ifdef BLINK_RATE_WRAP_EN
    test_wrap();
`else
    test_saturation();
`endif
    test_simultaneous();
    test_run_fall_with_press();
    test_stop_press();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
